// File: rtl/jtdsp16_rom_arb_if.sv
// Program-memory arbiter bus: three requester ports plus the shared memory port.
// The master side is the environment (requesters and memory); the slave side is the arbiter.
interface jtdsp16_rom_arb_if;
   logic        fetch_req;
   logic [15:0] fetch_addr;
   logic [15:0] fetch_data;
   logic        fetch_ok;

   logic        pt_req;
   logic [11:0] pt_addr;
   logic [15:0] pt_data;
   logic        pt_ok;

   logic        host_req;
   logic        host_we;
   logic [15:0] host_addr;
   logic [15:0] host_din;
   logic [15:0] host_dout;
   logic        host_ack;

   logic [15:0] mem_addr;
   logic [15:0] mem_din;
   logic        mem_we;
   logic [15:0] mem_dout;

   logic        pc_halt;

   modport master (
      output fetch_req, fetch_addr, pt_req, pt_addr,
             host_req, host_we, host_addr, host_din, mem_dout,
      input  fetch_data, fetch_ok, pt_data, pt_ok, host_dout, host_ack,
             mem_addr, mem_din, mem_we, pc_halt
   );

   modport slave (
      input  fetch_req, fetch_addr, pt_req, pt_addr,
             host_req, host_we, host_addr, host_din, mem_dout,
      output fetch_data, fetch_ok, pt_data, pt_ok, host_dout, host_ack,
             mem_addr, mem_din, mem_we, pc_halt
   );
endinterface

// File: rtl/jtdsp16_rom_arb.sv
// DSP16 program-memory arbiter: host > pt > fetch, with a starvation override for fetch,
// wait states for external addresses and a combinational pc_halt stall.
module jtdsp16_rom_arb #(
   parameter int unsigned INT_AW = 12,
   parameter int unsigned STARVE = 4
) (
   input logic              rst,
   input logic              clk,
   input logic              cen,
   input logic [3:0]        ws,
   jtdsp16_rom_arb_if.slave bus
);

   typedef enum logic {StIdle, StBusy} state_t;
   typedef enum logic [1:0] {OwnFetch, OwnPt, OwnHost} owner_t;

   state_t      state_q, state_d;
   owner_t      owner_q, gnt_owner;
   logic        host_wr_q;
   logic [3:0]  wcnt_q;
   logic [2:0]  starve_q;
   logic [15:0] gnt_addr;
   logic        grant, complete, can_grant, starving, ext;
   logic        want_fetch, want_pt, want_host;

   logic [15:0] fetch_data_q, pt_data_q, host_dout_q, mem_addr_q, mem_din_q;
   logic        fetch_ok_q, pt_ok_q, host_ack_q, mem_we_q;

   assign complete  = (state_q == StBusy) && (wcnt_q == 4'd0);
   assign can_grant = (state_q == StIdle) || complete;
   assign starving  = 32'(starve_q) >= STARVE;

   // The owner has not yet seen its ok, so its request is masked at regrant.
   assign want_fetch = bus.fetch_req & ~(complete && owner_q == OwnFetch);
   assign want_pt    = bus.pt_req    & ~(complete && owner_q == OwnPt);
   assign want_host  = bus.host_req  & ~(complete && owner_q == OwnHost);

   assign ext = (gnt_addr >> INT_AW) != 16'd0;

   // Grant selection: starving fetch first, then host, pt, fetch.
   always_comb begin
      grant     = 1'b0;
      gnt_owner = OwnFetch;
      gnt_addr  = bus.fetch_addr;
      if (can_grant) begin
         if (want_fetch && starving) begin
            grant = 1'b1;
         end else if (want_host) begin
            grant     = 1'b1;
            gnt_owner = OwnHost;
            gnt_addr  = bus.host_addr;
         end else if (want_pt) begin
            grant     = 1'b1;
            gnt_owner = OwnPt;
            gnt_addr  = {4'd0, bus.pt_addr};
         end else if (want_fetch) begin
            grant = 1'b1;
         end
      end
   end

   // Next state: every grant opportunity resolves to BUSY or IDLE.
   always_comb begin
      state_d = state_q;
      if (can_grant) state_d = grant ? StBusy : StIdle;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)      state_q <= StIdle;
      else if (cen) state_q <= state_d;
   end

   // Access datapath: wait count, completion capture, grant registration, starvation count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_q      <= OwnFetch;
         host_wr_q    <= 1'b0;
         wcnt_q       <= 4'd0;
         starve_q     <= 3'd0;
         fetch_data_q <= 16'd0;
         pt_data_q    <= 16'd0;
         host_dout_q  <= 16'd0;
         mem_addr_q   <= 16'd0;
         mem_din_q    <= 16'd0;
         fetch_ok_q   <= 1'b0;
         pt_ok_q      <= 1'b0;
         host_ack_q   <= 1'b0;
         mem_we_q     <= 1'b0;
      end else if (cen) begin
         fetch_ok_q <= 1'b0;
         pt_ok_q    <= 1'b0;
         host_ack_q <= 1'b0;
         mem_we_q   <= 1'b0;
         if (state_q == StBusy && wcnt_q != 4'd0) wcnt_q <= wcnt_q - 4'd1;
         if (complete) begin
            unique case (owner_q)
               OwnFetch: begin
                  fetch_data_q <= bus.mem_dout;
                  fetch_ok_q   <= 1'b1;
               end
               OwnPt: begin
                  pt_data_q <= bus.mem_dout;
                  pt_ok_q   <= 1'b1;
               end
               OwnHost: begin
                  if (!host_wr_q) host_dout_q <= bus.mem_dout;
                  host_ack_q <= 1'b1;
               end
               default: ;
            endcase
         end
         if (grant) begin
            owner_q    <= gnt_owner;
            mem_addr_q <= gnt_addr;
            wcnt_q     <= ext ? ws : 4'd0;
            host_wr_q  <= (gnt_owner == OwnHost) && bus.host_we;
            if (gnt_owner == OwnHost && bus.host_we) begin
               mem_din_q <= bus.host_din;
               mem_we_q  <= 1'b1;
            end
         end
         if (!bus.fetch_req) begin
            starve_q <= 3'd0;
         end else if (grant) begin
            if (gnt_owner == OwnFetch) starve_q <= 3'd0;
            else if (starve_q != 3'd7) starve_q <= starve_q + 3'd1;
         end
      end
   end

   assign bus.fetch_data = fetch_data_q;
   assign bus.fetch_ok   = fetch_ok_q;
   assign bus.pt_data    = pt_data_q;
   assign bus.pt_ok      = pt_ok_q;
   assign bus.host_dout  = host_dout_q;
   assign bus.host_ack   = host_ack_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_din    = mem_din_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.pc_halt    = bus.fetch_req & ~fetch_ok_q;

endmodule

// File: tb/tb_jtdsp16_rom_arb.sv
// Directed bench for jtdsp16_rom_arb: a scoreboard queue holds expected completions in
// service order; a negedge monitor pops it on every ok/ack pulse.
module tb_jtdsp16_rom_arb;
   localparam logic [1:0] SrcFetch = 2'd0;
   localparam logic [1:0] SrcPt    = 2'd1;
   localparam logic [1:0] SrcHost  = 2'd2;

   typedef struct {
      logic [1:0]  src;
      logic [15:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       cen;
   logic [3:0] ws;
   int         total = 0;
   int         bad = 0;
   exp_t       sb[$];
   logic       cen_at_edge = 1'b0;
   logic       wr_valid = 1'b0;
   logic [15:0] wr_addr = 16'd0;
   logic [15:0] wr_data = 16'd0;

   jtdsp16_rom_arb_if bus ();

   jtdsp16_rom_arb #(.INT_AW(12), .STARVE(4)) dut (
      .rst (rst),
      .clk (clk),
      .cen (cen),
      .ws  (ws),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] model(input logic [15:0] a);
      return a ^ {a[7:0], a[15:8]} ^ 16'hC35A;
   endfunction

   // Synchronous memory: address is already registered by the DUT, data follows it.
   always_comb begin
      bus.mem_dout = (wr_valid && bus.mem_addr == wr_addr) ? wr_data : model(bus.mem_addr);
   end

   always @(posedge clk) begin
      cen_at_edge <= cen;
      if (cen && bus.mem_we) begin
         wr_valid <= 1'b1;
         wr_addr  <= bus.mem_addr;
         wr_data  <= bus.mem_din;
      end
   end

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [1:0] src, input logic [15:0] data);
      exp_t e;
      e.src  = src;
      e.data = data;
      sb.push_back(e);
   endtask

   task automatic pop_chk(input logic [1:0] src, input logic [15:0] data);
      exp_t e;
      total++;
      assert (sb.size() != 0) else begin
         bad++;
         $error("FAIL unexpected_ok got=src%0d exp=none", src);
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("sb_src", 16'(src), 16'(e.src));
         chk("sb_data", data, e.data);
      end
   endtask

   // Monitor: count each pulse once, only when the preceding edge was a cen edge.
   always @(negedge clk) begin
      if (!rst && cen_at_edge) begin
         if (bus.fetch_ok) pop_chk(SrcFetch, bus.fetch_data);
         if (bus.pt_ok)    pop_chk(SrcPt, bus.pt_data);
         if (bus.host_ack) pop_chk(SrcHost, bus.host_dout);
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      int halts;
      int oks;
      rst = 1'b1;
      cen = 1'b1;
      ws  = 4'd0;
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 16'h0010;
      bus.pt_req     = 1'b0;
      bus.pt_addr    = 12'h000;
      bus.host_req   = 1'b0;
      bus.host_we    = 1'b0;
      bus.host_addr  = 16'h0000;
      bus.host_din   = 16'h0000;

      // Reset state
      tick;
      tick;
      chk("rst_mem_addr", bus.mem_addr, 16'h0000);
      chk("rst_mem_we", 16'(bus.mem_we), 16'h0000);
      chk("rst_fetch_ok", 16'(bus.fetch_ok), 16'h0000);
      chk("rst_fetch_data", bus.fetch_data, 16'h0000);
      chk("rst_pc_halt", 16'(bus.pc_halt), 16'h0001);
      rst = 1'b0;

      // Internal fetch: address after 1 cen, ok after 2 cen
      push(SrcFetch, model(16'h0010));
      tick;
      chk("f1_mem_addr", bus.mem_addr, 16'h0010);
      chk("f1_ok_early", 16'(bus.fetch_ok), 16'h0000);
      chk("f1_halt", 16'(bus.pc_halt), 16'h0001);
      tick;
      chk("f1_ok", 16'(bus.fetch_ok), 16'h0001);
      chk("f1_halt_ok", 16'(bus.pc_halt), 16'h0000);
      bus.fetch_req = 1'b0;
      tick;

      // External fetch, ws=3 latched at grant even though ws changes afterwards
      ws = 4'd3;
      bus.fetch_addr = 16'h2000;
      bus.fetch_req  = 1'b1;
      push(SrcFetch, model(16'h2000));
      halts = 0;
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         tick;
         if (i == 1) ws = 4'd0;
         n = i;
         if (bus.fetch_ok) break;
         if (bus.pc_halt) halts++;
      end
      chk("f2_latency", 16'(n), 16'd5);
      chk("f2_halts", 16'(halts), 16'd4);
      bus.fetch_req = 1'b0;
      tick;

      // pt and fetch raised together: pt first, fetch one cen later
      bus.pt_addr    = 12'h123;
      bus.pt_req     = 1'b1;
      bus.fetch_addr = 16'h0040;
      bus.fetch_req  = 1'b1;
      push(SrcPt, model(16'h0123));
      push(SrcFetch, model(16'h0040));
      tick;
      chk("p3_mem_addr", bus.mem_addr, 16'h0123);
      tick;
      chk("p3_pt_ok", 16'(bus.pt_ok), 16'h0001);
      bus.pt_req = 1'b0;
      tick;
      chk("p3_fetch_ok", 16'(bus.fetch_ok), 16'h0001);
      bus.fetch_req = 1'b0;
      tick;

      // Host read, then host write leaves host_dout alone, then pt reads the written word
      bus.host_addr = 16'h0007;
      bus.host_we   = 1'b0;
      bus.host_req  = 1'b1;
      push(SrcHost, model(16'h0007));
      tick;
      tick;
      chk("h4_rd_ack", 16'(bus.host_ack), 16'h0001);
      bus.host_req = 1'b0;
      tick;
      bus.host_addr = 16'h0005;
      bus.host_din  = 16'h1234;
      bus.host_we   = 1'b1;
      bus.host_req  = 1'b1;
      push(SrcHost, model(16'h0007));
      tick;
      chk("h4_we", 16'(bus.mem_we), 16'h0001);
      chk("h4_mem_din", bus.mem_din, 16'h1234);
      chk("h4_mem_addr", bus.mem_addr, 16'h0005);
      tick;
      chk("h4_we_clear", 16'(bus.mem_we), 16'h0000);
      chk("h4_wr_ack", 16'(bus.host_ack), 16'h0001);
      bus.host_req = 1'b0;
      bus.host_we  = 1'b0;
      bus.pt_addr  = 12'h005;
      bus.pt_req   = 1'b1;
      push(SrcPt, 16'h1234);
      tick;
      tick;
      chk("h4_readback_ok", 16'(bus.pt_ok), 16'h0001);
      bus.pt_req = 1'b0;
      tick;

      // Starvation: host and pt alternate, fetch wins the 5th grant
      bus.host_addr  = 16'h0030;
      bus.pt_addr    = 12'h031;
      bus.fetch_addr = 16'h0032;
      bus.host_req   = 1'b1;
      bus.pt_req     = 1'b1;
      bus.fetch_req  = 1'b1;
      push(SrcHost, model(16'h0030));
      push(SrcPt, model(16'h0031));
      push(SrcHost, model(16'h0030));
      push(SrcPt, model(16'h0031));
      push(SrcFetch, model(16'h0032));
      push(SrcHost, model(16'h0030));
      repeat (5) tick;
      chk("s5_fetch_granted", bus.mem_addr, 16'h0032);
      tick;
      chk("s5_fetch_ok", 16'(bus.fetch_ok), 16'h0001);
      bus.host_req  = 1'b0;
      bus.pt_req    = 1'b0;
      bus.fetch_req = 1'b0;
      tick;
      chk("s5_last_host", 16'(bus.host_ack), 16'h0001);
      tick;

      // Reset during an external access aborts it
      ws = 4'd5;
      bus.fetch_addr = 16'h3000;
      bus.fetch_req  = 1'b1;
      tick;
      tick;
      tick;
      rst = 1'b1;
      #1;
      chk("r6_mem_addr", bus.mem_addr, 16'h0000);
      chk("r6_fetch_data", bus.fetch_data, 16'h0000);
      chk("r6_pt_data", bus.pt_data, 16'h0000);
      chk("r6_host_dout", bus.host_dout, 16'h0000);
      chk("r6_mem_din", bus.mem_din, 16'h0000);
      chk("r6_pc_halt", 16'(bus.pc_halt), 16'h0001);
      bus.fetch_req = 1'b0;
      tick;
      rst = 1'b0;
      oks = 0;
      for (int i = 0; i < 8; i++) begin
         tick;
         if (bus.fetch_ok || bus.pt_ok || bus.host_ack) oks++;
      end
      chk("r6_no_ok", 16'(oks), 16'd0);
      bus.fetch_addr = 16'h0050;
      bus.fetch_req  = 1'b1;
      push(SrcFetch, model(16'h0050));
      tick;
      tick;
      chk("r6_new_fetch_ok", 16'(bus.fetch_ok), 16'h0001);
      bus.fetch_req = 1'b0;
      tick;

      // cen=0 holds the ok pulse
      bus.fetch_addr = 16'h0060;
      bus.fetch_req  = 1'b1;
      push(SrcFetch, model(16'h0060));
      tick;
      tick;
      chk("c7_ok", 16'(bus.fetch_ok), 16'h0001);
      cen = 1'b0;
      bus.fetch_req = 1'b0;
      tick;
      tick;
      chk("c7_ok_held", 16'(bus.fetch_ok), 16'h0001);
      cen = 1'b1;
      tick;
      chk("c7_ok_clear", 16'(bus.fetch_ok), 16'h0000);
      tick;

      chk("sb_drained", 16'(sb.size()), 16'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
